// File: rtl/image_op_pkg.sv
// Shared definitions for the image operation controller: pixel width,
// operation codes, FSM state type and the gray-level helper.
package image_op_pkg;

  localparam int PIX_W = 8;

  localparam logic [2:0] OP_PASS       = 3'd0;
  localparam logic [2:0] OP_GRAY       = 3'd1;
  localparam logic [2:0] OP_INVERT     = 3'd2;
  localparam logic [2:0] OP_THRESH     = 3'd3;
  localparam logic [2:0] OP_BRIGHT_INC = 3'd4;
  localparam logic [2:0] OP_BRIGHT_DEC = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Truncating average of the three components; the sum needs two extra bits.
  function automatic logic [PIX_W-1:0] gray_of(input logic [PIX_W-1:0] r,
                                               input logic [PIX_W-1:0] g,
                                               input logic [PIX_W-1:0] b);
    logic [PIX_W+1:0] sum;
    sum = {2'b00, r} + {2'b00, g} + {2'b00, b};
    return PIX_W'(sum / (PIX_W+2)'(3));
  endfunction

endpackage

// File: rtl/pixel_op_alu.sv
// Combinational per-pixel arithmetic for image_op_controller.
// Build option: define IMAGE_OP_SAT_EN to make BRIGHT_INC/BRIGHT_DEC saturate
// instead of wrapping modulo 256.
module pixel_op_alu
  import image_op_pkg::*;
(
  input  logic [2:0]       op,
  input  logic [PIX_W-1:0] param,
  input  logic [PIX_W-1:0] r,
  input  logic [PIX_W-1:0] g,
  input  logic [PIX_W-1:0] b,
  output logic [PIX_W-1:0] res_r,
  output logic [PIX_W-1:0] res_g,
  output logic [PIX_W-1:0] res_b
);

  logic [PIX_W-1:0] gray;
  logic [PIX_W-1:0] inv;
  logic [PIX_W-1:0] thr;
  logic [PIX_W-1:0] chan_in  [3];
  logic [PIX_W-1:0] chan_out [3];

  assign gray = gray_of(r, g, b);
  assign inv  = {PIX_W{1'b1}} - gray;
  assign thr  = (gray > param) ? {PIX_W{1'b1}} : {PIX_W{1'b0}};

  // Channel order is fixed: index 0 = red, 1 = green, 2 = blue.
  assign chan_in[0] = r;
  assign chan_in[1] = g;
  assign chan_in[2] = b;
  assign res_r = chan_out[0];
  assign res_g = chan_out[1];
  assign res_b = chan_out[2];

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_chan
      logic [PIX_W-1:0] inc_val;
      logic [PIX_W-1:0] dec_val;
      logic [PIX_W-1:0] res;

`ifdef IMAGE_OP_SAT_EN
      logic [PIX_W:0] inc_sum;
      logic [PIX_W:0] dec_diff;
      assign inc_sum  = {1'b0, chan_in[gi]} + {1'b0, param};
      assign dec_diff = {1'b0, chan_in[gi]} - {1'b0, param};
      // Carry out clamps to full scale, borrow clamps to zero.
      assign inc_val  = inc_sum[PIX_W]  ? {PIX_W{1'b1}} : inc_sum[PIX_W-1:0];
      assign dec_val  = dec_diff[PIX_W] ? {PIX_W{1'b0}} : dec_diff[PIX_W-1:0];
`else
      assign inc_val  = chan_in[gi] + param;
      assign dec_val  = chan_in[gi] - param;
`endif

      // Select this channel's result from the operation code.
      always_comb begin
        res = chan_in[gi];
        case (op)
          OP_GRAY:       res = gray;
          OP_INVERT:     res = inv;
          OP_THRESH:     res = thr;
          OP_BRIGHT_INC: res = inc_val;
          OP_BRIGHT_DEC: res = dec_val;
          default:       res = chan_in[gi];
        endcase
      end

      assign chan_out[gi] = res;
    end
  endgenerate

endmodule

// File: rtl/image_op_controller.sv
// Frame sequencer for streaming pixel operations: start/op/param launch,
// valid/ready pixel pipeline with one output register stage, row/column
// tagging and done pulse. Arithmetic lives in pixel_op_alu.
// Build option: IMAGE_OP_SAT_EN (saturating brightness, see pixel_op_alu).
module image_op_controller
  import image_op_pkg::*;
#(
  parameter int HEIGHT = 768,
  parameter int WIDTH  = 512
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [PIX_W-1:0] param,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_r,
  input  logic [PIX_W-1:0] in_g,
  input  logic [PIX_W-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_r,
  output logic [PIX_W-1:0] out_g,
  output logic [PIX_W-1:0] out_b,
  output logic             out_sof,
  output logic             out_eol,
  output logic             out_eof,
  output logic             busy,
  output logic             done
);

  localparam int COL_W = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

  state_t           state_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [2:0]       op_reg;
  logic [PIX_W-1:0] param_reg;
  logic [COL_W-1:0] col_reg;
  logic [ROW_W-1:0] row_reg;

  logic             out_valid_reg;
  logic [PIX_W-1:0] out_r_reg;
  logic [PIX_W-1:0] out_g_reg;
  logic [PIX_W-1:0] out_b_reg;
  logic             out_sof_reg;
  logic             out_eol_reg;
  logic             out_eof_reg;

  logic             accept;
  logic             take;
  logic             col_last;
  logic             row_last;
  logic             pix_last;
  logic [PIX_W-1:0] alu_r;
  logic [PIX_W-1:0] alu_g;
  logic [PIX_W-1:0] alu_b;

  // The output register can take a new pixel when empty or being drained.
  assign in_ready = (state_reg == ST_RUN) && (!out_valid_reg || out_ready);
  assign accept   = in_valid && in_ready;
  assign take     = out_valid_reg && out_ready;
  assign col_last = (col_reg == COL_LAST);
  assign row_last = (row_reg == ROW_LAST);
  assign pix_last = col_last && row_last;

  assign out_valid = out_valid_reg;
  assign out_r     = out_r_reg;
  assign out_g     = out_g_reg;
  assign out_b     = out_b_reg;
  assign out_sof   = out_sof_reg;
  assign out_eol   = out_eol_reg;
  assign out_eof   = out_eof_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;

  pixel_op_alu u_alu (
    .op    (op_reg),
    .param (param_reg),
    .r     (in_r),
    .g     (in_g),
    .b     (in_b),
    .res_r (alu_r),
    .res_g (alu_g),
    .res_b (alu_b)
  );

  // Frame FSM with registered busy/done flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg <= ST_RUN;
            busy_reg  <= 1'b1;
          end
        end
        ST_RUN: begin
          if (accept && pix_last) begin
            state_reg <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          // The last pixel sits in the output register; finish once it leaves.
          if (take) begin
            state_reg <= ST_DONE;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b1;
          end
        end
        ST_DONE: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  // Frame context: op/param latched at launch, raster position per accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_reg    <= OP_PASS;
      param_reg <= '0;
      col_reg   <= '0;
      row_reg   <= '0;
    end else if ((state_reg == ST_IDLE) && start) begin
      op_reg    <= op;
      param_reg <= param;
      col_reg   <= '0;
      row_reg   <= '0;
    end else if (accept) begin
      if (col_last) begin
        col_reg <= '0;
        row_reg <= row_last ? '0 : row_reg + 1'b1;
      end else begin
        col_reg <= col_reg + 1'b1;
      end
    end
  end

  // Output stage: load on accept, hold while stalled, empty when drained.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_reg <= 1'b0;
      out_r_reg     <= '0;
      out_g_reg     <= '0;
      out_b_reg     <= '0;
      out_sof_reg   <= 1'b0;
      out_eol_reg   <= 1'b0;
      out_eof_reg   <= 1'b0;
    end else if (accept) begin
      out_valid_reg <= 1'b1;
      out_r_reg     <= alu_r;
      out_g_reg     <= alu_g;
      out_b_reg     <= alu_b;
      out_sof_reg   <= (row_reg == '0) && (col_reg == '0);
      out_eol_reg   <= col_last;
      out_eof_reg   <= pix_last;
    end else if (out_ready) begin
      out_valid_reg <= 1'b0;
    end
  end

endmodule

// File: tb/tb_image_op_controller.sv
// Self-checking bench for image_op_controller on a 2x3 frame: table vectors,
// randomized frames against a reference model, stall, mid-frame reset and
// ignored re-start sequences. One line printed per frame.
module tb_image_op_controller;
  import image_op_pkg::*;

  localparam int H = 2;
  localparam int W = 3;
  localparam int N = H * W;

  logic       clk = 1'b0;
  logic       rst, start, in_valid, in_ready, out_valid, out_ready;
  logic [2:0] op;
  logic [7:0] param, in_r, in_g, in_b, out_r, out_g, out_b;
  logic       out_sof, out_eol, out_eof, busy, done;

  always #5 clk = ~clk;

  image_op_controller #(.HEIGHT(H), .WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .param(param),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_r(in_r), .in_g(in_g), .in_b(in_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_r(out_r), .out_g(out_g), .out_b(out_b),
    .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof),
    .busy(busy), .done(done)
  );

  typedef struct packed { logic [7:0] r; logic [7:0] g; logic [7:0] b; } pix_t;
  typedef struct { int op; int param; pix_t in_px; pix_t exp_px; } vec_t;

  int   checks = 0;
  int   errors = 0;
  pix_t in_px  [N];
  pix_t exp_px [N];
  vec_t vt [$];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input int o, input int p, input int r, input int g, input int b,
                              input int er, input int eg, input int eb);
    vec_t v;
    v.op = o; v.param = p;
    v.in_px  = {8'(r), 8'(g), 8'(b)};
    v.exp_px = {8'(er), 8'(eg), 8'(eb)};
    return v;
  endfunction

  // Reference: plain integer arithmetic straight from the operation rules.
  function automatic pix_t ref_op(input int o, input int p, input pix_t x);
    int c[3];
    int gy;
    c[0] = int'(x.r); c[1] = int'(x.g); c[2] = int'(x.b);
    gy = (c[0] + c[1] + c[2]) / 3;
    for (int k = 0; k < 3; k++) begin
      case (o)
        1: c[k] = gy;
        2: c[k] = 255 - gy;
        3: c[k] = (gy > p) ? 255 : 0;
`ifdef IMAGE_OP_SAT_EN
        4: c[k] = (c[k] + p > 255) ? 255 : c[k] + p;
        5: c[k] = (c[k] - p < 0) ? 0 : c[k] - p;
`else
        4: c[k] = (c[k] + p) % 256;
        5: c[k] = (c[k] - p + 256) % 256;
`endif
        default: ;
      endcase
    end
    return {8'(c[0]), 8'(c[1]), 8'(c[2])};
  endfunction

  // mode 0: full rate; 1: random valid/ready; 2: out_ready low 5 cycles mid-frame.
  task automatic run_frame(input int op_i, input int param_i, input int mode,
                           input bit repulse, input string name);
    int   sent = 0, got = 0, cyc = 0;
    int   first_acc = -1, first_take = -1, last_take = -1;
    int   err0 = errors;
    bit   stall_prev = 0, done_seen = 0, busy_low = 0, rdy_bad = 0;
    int   prev_out = 0;
    @(negedge clk);
    start = 1'b1; op = 3'(op_i); param = 8'(param_i); in_valid = 1'b0; out_ready = 1'b1;
    while (got < N && cyc < 300) begin
      @(negedge clk);
      start = repulse && (cyc == 2);
      if (start) begin op = OP_BRIGHT_DEC; param = 8'd33; end
      case (mode)
        0:       out_ready = 1'b1;
        1:       out_ready = ($urandom_range(0, 3) != 0);
        default: out_ready = !(cyc >= 3 && cyc < 8);
      endcase
      in_valid = (sent < N) && (mode != 1 || $urandom_range(0, 2) != 0);
      if (sent < N) {in_r, in_g, in_b} = in_px[sent];
      else {in_r, in_g, in_b} = 24'($urandom);
      #1;
      if (done) done_seen = 1;
      if (!busy) busy_low = 1;
      if (out_valid && !out_ready && in_ready) rdy_bad = 1;
      if (stall_prev) begin
        chk("hold_valid", int'(out_valid), 1);
        chk("hold_data", int'({out_r, out_g, out_b, out_sof, out_eol, out_eof}), prev_out);
      end
      if (out_valid && out_ready) begin
        chk($sformatf("%s_pix%0d", name, got), int'({out_r, out_g, out_b}), int'(exp_px[got]));
        chk($sformatf("%s_tags%0d", name, got), int'({out_sof, out_eol, out_eof}),
            int'({got == 0, (got % W) == W - 1, got == N - 1}));
        if (first_take < 0) first_take = cyc;
        last_take = cyc;
        got++;
      end
      if (in_valid && in_ready) begin
        if (first_acc < 0) first_acc = cyc;
        sent++;
      end
      stall_prev = out_valid && !out_ready;
      prev_out   = int'({out_r, out_g, out_b, out_sof, out_eol, out_eof});
      cyc++;
    end
    chk({name, "_timeout"}, got, N);
    chk({name, "_no_early_done"}, int'(done_seen), 0);
    chk({name, "_busy_in_frame"}, int'(busy_low), 0);
    chk({name, "_in_ready_stall"}, int'(rdy_bad), 0);
    if (mode == 0) begin
      chk({name, "_latency"}, first_take - first_acc, 1);
      chk({name, "_throughput"}, last_take - first_take, N - 1);
    end
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    chk({name, "_done_pulse"}, int'(done), 1);
    chk({name, "_busy_at_done"}, int'(busy), 0);
    @(negedge clk);
    #1;
    chk({name, "_done_clear"}, int'(done), 0);
    chk({name, "_idle_in_ready"}, int'(in_ready), 0);
    $display("frame %-10s op=%0d param=%0d mode=%0d outputs=%0d cycles=%0d new_errors=%0d",
             name, op_i, param_i, mode, got, cyc, errors - err0);
  endtask

  initial begin
    int acc;
    rst = 1'b1; start = 1'b0; op = '0; param = '0; in_valid = 1'b0; out_ready = 1'b1;
    in_r = '0; in_g = '0; in_b = '0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'({out_r, out_g, out_b}), 0);
    chk("rst_tags", int'({out_sof, out_eol, out_eof}), 0);
    chk("rst_busy_done", int'({busy, done}), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    rst = 1'b0;

    // Table vectors: each runs a full frame of one repeated pixel.
    vt.push_back(mk(1, 0, 30, 60, 90, 60, 60, 60));
    vt.push_back(mk(3, 90, 91, 91, 91, 255, 255, 255));
    vt.push_back(mk(3, 90, 90, 90, 90, 0, 0, 0));
    vt.push_back(mk(0, 0, 1, 2, 3, 1, 2, 3));
    vt.push_back(mk(2, 0, 0, 0, 0, 255, 255, 255));
    vt.push_back(mk(2, 0, 255, 255, 255, 0, 0, 0));
    vt.push_back(mk(6, 9, 7, 8, 9, 7, 8, 9));
    vt.push_back(mk(7, 9, 200, 100, 50, 200, 100, 50));
    vt.push_back(mk(1, 0, 255, 255, 255, 255, 255, 255));
    vt.push_back(mk(1, 0, 1, 1, 0, 0, 0, 0));
    vt.push_back(mk(3, 255, 255, 255, 255, 0, 0, 0));
    vt.push_back(mk(3, 0, 1, 1, 1, 255, 255, 255));
`ifdef IMAGE_OP_SAT_EN
    vt.push_back(mk(4, 100, 200, 10, 250, 255, 110, 255));
    vt.push_back(mk(5, 50, 30, 100, 50, 0, 50, 0));
    vt.push_back(mk(4, 255, 1, 0, 255, 255, 255, 255));
`else
    vt.push_back(mk(4, 100, 200, 10, 250, 44, 110, 94));
    vt.push_back(mk(5, 50, 30, 100, 50, 236, 50, 0));
    vt.push_back(mk(4, 255, 1, 0, 255, 0, 255, 254));
`endif
    for (int i = 0; i < vt.size(); i++) begin
      for (int k = 0; k < N; k++) begin
        in_px[k] = vt[i].in_px;
        exp_px[k] = vt[i].exp_px;
      end
      run_frame(vt[i].op, vt[i].param, 0, 1'b0, $sformatf("vec%0d", i));
    end

    // Threshold boundary inside one frame: alternating 91 / 90 at param 90.
    for (int k = 0; k < N; k++) begin
      in_px[k]  = (k % 2 == 0) ? {8'd91, 8'd91, 8'd91} : {8'd90, 8'd90, 8'd90};
      exp_px[k] = (k % 2 == 0) ? {8'd255, 8'd255, 8'd255} : 24'd0;
    end
    run_frame(3, 90, 0, 1'b0, "thr_edge");

    // Randomized frames with random valid/ready against the model.
    for (int f = 0; f < 8; f++) begin
      int ro, rp;
      ro = $urandom_range(0, 7);
      rp = $urandom_range(0, 255);
      for (int k = 0; k < N; k++) begin
        in_px[k]  = 24'($urandom);
        exp_px[k] = ref_op(ro, rp, in_px[k]);
      end
      run_frame(ro, rp, 1, 1'b0, $sformatf("rand%0d", f));
    end

    // Output stall of 5 cycles mid-frame.
    for (int k = 0; k < N; k++) begin
      in_px[k]  = {8'(10 * k + 5), 8'(20 * k), 8'(250 - k)};
      exp_px[k] = ref_op(4, 17, in_px[k]);
    end
    run_frame(4, 17, 2, 1'b0, "stall");

    // Start re-pulsed with op 5 during RUN must be ignored.
    for (int k = 0; k < N; k++) begin
      in_px[k]  = {8'd30, 8'd60, 8'd90};
      exp_px[k] = {8'd60, 8'd60, 8'd60};
    end
    run_frame(1, 0, 0, 1'b1, "repulse");

    // Mid-frame reset after two accepted pixels.
    @(negedge clk);
    start = 1'b1; op = OP_PASS; param = '0; in_valid = 1'b0;
    @(negedge clk);
    start = 1'b0; in_valid = 1'b1; out_ready = 1'b1; {in_r, in_g, in_b} = {8'd9, 8'd9, 8'd9};
    acc = 0;
    for (int k = 0; k < 20 && acc < 2; k++) begin
      #1;
      if (in_valid && in_ready) acc++;
      @(negedge clk);
    end
    chk("mid_rst_accepts", acc, 2);
    in_valid = 1'b0;
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      #1;
      chk("mid_rst_outputs", int'({out_valid, out_r, out_g, out_b, out_sof, out_eol, out_eof}), 0);
      chk("mid_rst_busy_done", int'({busy, done}), 0);
    end
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1;
      chk("post_rst_no_done", int'({busy, done}), 0);
    end
    $display("frame %-10s abandoned after %0d pixels by reset", "mid_rst", acc);
    for (int k = 0; k < N; k++) begin
      in_px[k]  = 24'd0;
      exp_px[k] = {8'd255, 8'd255, 8'd255};
    end
    run_frame(2, 0, 0, 1'b0, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
